// File: rtl/keypress_pkg.sv
// Keypad scanner shared types.
// Used by module_keypress and module_row_encoder.
package keypress_pkg;

  typedef logic [1:0] row_code_t;
  typedef logic [1:0] col_code_t;
  typedef logic [3:0] key_code_t;

  localparam logic [3:0] ROW_NONE = 4'b1111;

endpackage

// File: rtl/module_row_encoder.sv
// Active-low one-hot row sense decoder.
// Purely combinational: row code plus valid/none/multi flags.
module module_row_encoder
  import keypress_pkg::*;
(
  input  logic [3:0] posf,
  output row_code_t  row_code,
  output logic       valid,
  output logic       none,
  output logic       multi
);

  always_comb begin
    row_code = '0;
    valid    = 1'b0;
    none     = 1'b0;
    multi    = 1'b0;
    unique case (1'b1)
      (posf == 4'b1110): begin
        row_code = 2'd0;
        valid    = 1'b1;
      end
      (posf == 4'b1101): begin
        row_code = 2'd1;
        valid    = 1'b1;
      end
      (posf == 4'b1011): begin
        row_code = 2'd2;
        valid    = 1'b1;
      end
      (posf == 4'b0111): begin
        row_code = 2'd3;
        valid    = 1'b1;
      end
      (posf == ROW_NONE): none = 1'b1;
      default:            multi = 1'b1;
    endcase
  end

endmodule

// File: rtl/module_keypress.sv
// Keypad row/column capture with synchronizer and debounce.
// KEYPRESS_DEBOUNCE_EN selects the counter; undefined accepts on first sample.
module module_keypress
  import keypress_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] dato_codc_i,
  input  logic [3:0] posf_i,
  output logic [1:0] dato_codf_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_strobe_o,
  output logic       multi_err_o
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= (1 << CNT_W))
  begin : g_bad_cfg
    $error("module_keypress: DEBOUNCE_CYCLES out of range");
  end

  logic [3:0] posf_s1, posf_s2;
  col_code_t  col_s1, col_s2;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      posf_s1 <= ROW_NONE;
      posf_s2 <= ROW_NONE;
      col_s1  <= '0;
      col_s2  <= '0;
    end else begin
      posf_s1 <= posf_i;
      posf_s2 <= posf_s1;
      col_s1  <= dato_codc_i;
      col_s2  <= col_s1;
    end
  end

  row_code_t row;
  logic      valid, none, multi;

  module_row_encoder u_enc (
    .posf     (posf_s2),
    .row_code (row),
    .valid    (valid),
    .none     (none),
    .multi    (multi)
  );

  // Second decoder looks one stage early so multi_err_o lines up with posf_s2.
  row_code_t unused_s1_row;
  logic      unused_s1_valid, unused_s1_none;
  logic      s1_multi;

  module_row_encoder u_enc_err (
    .posf     (posf_s1),
    .row_code (unused_s1_row),
    .valid    (unused_s1_valid),
    .none     (unused_s1_none),
    .multi    (s1_multi)
  );

  logic samp_chg;
  logic fire;

  assign samp_chg = {posf_s1, col_s1} != {posf_s2, col_s2};

`ifdef KEYPRESS_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  // cnt = cycles the current sample has been stable, minus one.
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (samp_chg || multi) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign fire = (cnt == CNT_ACC) && !multi;
`else
  logic first;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      first <= 1'b0;
    end else begin
      first <= samp_chg;
    end
  end

  assign fire = first;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dato_codf_o  <= '0;
      key_code_o   <= '0;
      key_valid_o  <= 1'b0;
      key_strobe_o <= 1'b0;
      multi_err_o  <= 1'b0;
    end else begin
      key_strobe_o <= 1'b0;
      multi_err_o  <= s1_multi;
      if (fire && valid) begin
        dato_codf_o  <= row;
        key_code_o   <= {row, col_s2};
        key_valid_o  <= 1'b1;
        key_strobe_o <= 1'b1;
      end else if (fire && none) begin
        key_valid_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_module_keypress.sv
// Directed bench for module_keypress.
// Expected timing follows KEYPRESS_DEBOUNCE_EN (4 cycles) or 1 cycle.
module tb_module_keypress;

`ifdef KEYPRESS_DEBOUNCE_EN
  localparam int EFF = 4;
`else
  localparam int EFF = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] col = 2'b00;
  logic [3:0] posf = 4'b1111;
  logic [1:0] dato_codf;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_strobe;
  logic       multi_err;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  module_keypress #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (16)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .dato_codc_i  (col),
    .posf_i       (posf),
    .dato_codf_o  (dato_codf),
    .key_code_o   (key_code),
    .key_valid_o  (key_valid),
    .key_strobe_o (key_strobe),
    .multi_err_o  (multi_err)
  );

  always @(negedge clk) begin
    if (key_strobe === 1'b1) strobe_cnt = strobe_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] c, input logic [3:0] p,
                       input int n);
    col  = c;
    posf = p;
    step(n);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    col   = 2'b11;
    posf  = 4'b0111;
    step(3);
    tests++;
    if (dato_codf !== 2'b00) begin
      fails++;
      $display("FAIL rst_dato: got %b want 00", dato_codf);
    end
    tests++;
    if (key_code !== 4'b0000) begin
      fails++;
      $display("FAIL rst_code: got %b want 0000", key_code);
    end
    tests++;
    if (key_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid: got %b want 0", key_valid);
    end
    tests++;
    if (key_strobe !== 1'b0) begin
      fails++;
      $display("FAIL rst_strobe: got %b want 0", key_strobe);
    end
    tests++;
    if (multi_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_multi: got %b want 0", multi_err);
    end
    posf  = 4'b1111;
    col   = 2'b00;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_idle;
    int s0;
    s0 = strobe_cnt;
    press(2'b00, 4'b1111, 20);
    tests++;
    if (dato_codf !== 2'b00) begin
      fails++;
      $display("FAIL idle_dato: got %b want 00", dato_codf);
    end
    tests++;
    if (key_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_valid: got %b want 0", key_valid);
    end
    tests++;
    if (strobe_cnt - s0 != 0) begin
      fails++;
      $display("FAIL idle_strobe: got %0d want 0", strobe_cnt - s0);
    end
  endtask

  task automatic test_latency;
    int s0;
    int lat;
    logic stb;
    s0   = strobe_cnt;
    lat  = -1;
    stb  = 1'b0;
    col  = 2'b01;
    posf = 4'b1101;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (lat < 0 && key_valid === 1'b1) begin
        lat = i;
        stb = key_strobe;
      end
    end
    tests++;
    if (lat != 2 + EFF) begin
      fails++;
      $display("FAIL lat_cycles: got %0d want %0d", lat, 2 + EFF);
    end
    tests++;
    if (stb !== 1'b1) begin
      fails++;
      $display("FAIL lat_strobe: got %b want 1", stb);
    end
    tests++;
    if (strobe_cnt - s0 != 1) begin
      fails++;
      $display("FAIL lat_count: got %0d want 1", strobe_cnt - s0);
    end
    tests++;
    if (key_code !== 4'b0101) begin
      fails++;
      $display("FAIL lat_code: got %b want 0101", key_code);
    end
    press(2'b01, 4'b1111, 10);
  endtask

  task automatic test_all_keys;
    logic [3:0] pats [4];
    logic [3:0] exp;
    int s0;
    pats[0] = 4'b1110;
    pats[1] = 4'b1101;
    pats[2] = 4'b1011;
    pats[3] = 4'b0111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        exp = {r[1:0], c[1:0]};
        s0  = strobe_cnt;
        press(c[1:0], pats[r], 10);
        tests++;
        if (dato_codf !== r[1:0]) begin
          fails++;
          $display("FAIL key_dato c%0d r%0d: got %b want %b",
                   c, r, dato_codf, r[1:0]);
        end
        tests++;
        if (key_code !== exp) begin
          fails++;
          $display("FAIL key_code c%0d r%0d: got %b want %b",
                   c, r, key_code, exp);
        end
        tests++;
        if (key_valid !== 1'b1) begin
          fails++;
          $display("FAIL key_valid c%0d r%0d: got %b want 1",
                   c, r, key_valid);
        end
        tests++;
        if (strobe_cnt - s0 != 1) begin
          fails++;
          $display("FAIL key_strobes c%0d r%0d: got %0d want 1",
                   c, r, strobe_cnt - s0);
        end
        press(c[1:0], 4'b1111, 10);
        tests++;
        if (key_valid !== 1'b0) begin
          fails++;
          $display("FAIL rel_valid c%0d r%0d: got %b want 0",
                   c, r, key_valid);
        end
        tests++;
        if (key_code !== exp) begin
          fails++;
          $display("FAIL rel_hold c%0d r%0d: got %b want %b",
                   c, r, key_code, exp);
        end
      end
    end
  endtask

  task automatic test_bounce;
    int s0;
    int exp_stb;
    logic seen;
    logic exp_seen;
    s0       = strobe_cnt;
    seen     = 1'b0;
    exp_stb  = (EFF <= 2) ? 4 : 0;
    exp_seen = (EFF <= 2);
    col      = 2'b01;
    for (int k = 0; k < 4; k++) begin
      posf = 4'b1101;
      step(1);
      seen = seen | key_valid;
      step(1);
      seen = seen | key_valid;
      posf = 4'b1111;
      step(1);
      seen = seen | key_valid;
      step(1);
      seen = seen | key_valid;
    end
    step(10);
    tests++;
    if (strobe_cnt - s0 != exp_stb) begin
      fails++;
      $display("FAIL bounce_strobes: got %0d want %0d",
               strobe_cnt - s0, exp_stb);
    end
    tests++;
    if (seen !== exp_seen) begin
      fails++;
      $display("FAIL bounce_valid: got %b want %b", seen, exp_seen);
    end
    tests++;
    if (key_valid !== 1'b0) begin
      fails++;
      $display("FAIL bounce_end: got %b want 0", key_valid);
    end
  endtask

  task automatic test_multi;
    int s0;
    press(2'b01, 4'b1011, 10);
    s0   = strobe_cnt;
    col  = 2'b10;
    posf = 4'b0000;
    step(1);
    tests++;
    if (multi_err !== 1'b0) begin
      fails++;
      $display("FAIL multi_early: got %b want 0", multi_err);
    end
    step(1);
    tests++;
    if (multi_err !== 1'b1) begin
      fails++;
      $display("FAIL multi_rise: got %b want 1", multi_err);
    end
    step(10);
    tests++;
    if (multi_err !== 1'b1) begin
      fails++;
      $display("FAIL multi_hold: got %b want 1", multi_err);
    end
    tests++;
    if (dato_codf !== 2'b10) begin
      fails++;
      $display("FAIL multi_dato: got %b want 10", dato_codf);
    end
    tests++;
    if (key_code !== 4'b1001) begin
      fails++;
      $display("FAIL multi_code: got %b want 1001", key_code);
    end
    tests++;
    if (key_valid !== 1'b1) begin
      fails++;
      $display("FAIL multi_valid: got %b want 1", key_valid);
    end
    tests++;
    if (strobe_cnt - s0 != 0) begin
      fails++;
      $display("FAIL multi_strobe: got %0d want 0", strobe_cnt - s0);
    end
    press(2'b10, 4'b1111, 10);
    tests++;
    if (multi_err !== 1'b0) begin
      fails++;
      $display("FAIL multi_clear: got %b want 0", multi_err);
    end
    tests++;
    if (key_valid !== 1'b0) begin
      fails++;
      $display("FAIL multi_relv: got %b want 0", key_valid);
    end
  endtask

  task automatic test_back_to_back;
    int s0;
    press(2'b00, 4'b1110, 10);
    s0 = strobe_cnt;
    press(2'b11, 4'b0111, 10);
    tests++;
    if (strobe_cnt - s0 != 1) begin
      fails++;
      $display("FAIL b2b_strobe: got %0d want 1", strobe_cnt - s0);
    end
    tests++;
    if (key_code !== 4'b1111) begin
      fails++;
      $display("FAIL b2b_code: got %b want 1111", key_code);
    end
    press(2'b11, 4'b0111, 40);
    tests++;
    if (strobe_cnt - s0 != 1) begin
      fails++;
      $display("FAIL b2b_hold: got %0d want 1", strobe_cnt - s0);
    end
    tests++;
    if (key_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_valid: got %b want 1", key_valid);
    end
    press(2'b11, 4'b1111, 10);
  endtask

  task automatic test_reset_mid;
    int s0;
    int lat;
    press(2'b11, 4'b0111, 10);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({dato_codf, key_code, key_valid, key_strobe, multi_err}
        !== 9'b0) begin
      fails++;
      $display("FAIL rmid_outs: got %b %b %b %b %b want all 0",
               dato_codf, key_code, key_valid, key_strobe, multi_err);
    end
    step(2);
    s0    = strobe_cnt;
    lat   = -1;
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (lat < 0 && key_valid === 1'b1) lat = i;
    end
    tests++;
    if (lat != 2 + EFF) begin
      fails++;
      $display("FAIL rmid_lat: got %0d want %0d", lat, 2 + EFF);
    end
    tests++;
    if (strobe_cnt - s0 != 1) begin
      fails++;
      $display("FAIL rmid_strobe: got %0d want 1", strobe_cnt - s0);
    end
    tests++;
    if (key_code !== 4'b1111) begin
      fails++;
      $display("FAIL rmid_code: got %b want 1111", key_code);
    end
    tests++;
    if (dato_codf !== 2'b11) begin
      fails++;
      $display("FAIL rmid_dato: got %b want 11", dato_codf);
    end
    press(2'b11, 4'b1111, 10);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_latency();
    test_all_keys();
    test_bounce();
    test_multi();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
